// File: rtl/audio_output_mc.sv
// Multi-channel delta-sigma audio output: valid/ready frame FIFO, rate-timed sample
// fetch with underrun handling, and a first- or second-order 1-bit modulator per channel.
module audio_output_mc #(
   parameter int CHANNELS           = 2,
   parameter int SAMPLE_WIDTH       = 16,
   parameter int FIFO_DEPTH_IN_BITS = 3,
   parameter int READ_FREQ          = 374,
   parameter int ORDER              = 1,
   parameter int SIGNED_IN          = 0,
   parameter int HOLD_ON_UNDERRUN   = 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [CHANNELS*SAMPLE_WIDTH-1:0] data,
   input  logic                             valid,
   output logic                             ready,
   output logic [FIFO_DEPTH_IN_BITS:0]      fifo_level,
   output logic                             underrun,
   input  logic                             underrun_clear,
   output logic                             sample_tick,
   output logic [CHANNELS-1:0]              audio_out
);

   localparam int W     = SAMPLE_WIDTH;
   localparam int FW    = CHANNELS * SAMPLE_WIDTH;
   localparam int AW    = FIFO_DEPTH_IN_BITS;
   localparam int DEPTH = 1 << FIFO_DEPTH_IN_BITS;
   localparam int CW    = (READ_FREQ > 0) ? $clog2(READ_FREQ + 1) : 1;

   localparam logic [W-1:0]  MID     = {1'b1, {(W-1){1'b0}}};
   localparam logic [CW-1:0] RELOAD  = CW'(READ_FREQ);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
   localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);

   logic [FW-1:0] mem_r [DEPTH];
   logic [FW-1:0] wr_word_s;
   logic [FW-1:0] rd_word_r;
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   level_r;
   logic [AW:0]   level_next_s;
   logic          ready_r;
   logic [CW-1:0] cnt_r;
   logic          tick_s;
   logic          push_s;
   logic          pop_s;
   logic          sample_tick_r;
   logic          load_pend_r;
   logic          load_pop_r;
   logic          underrun_r;

   generate
      if (ORDER != 1 && ORDER != 2) begin : g_bad_order
         $error("audio_output_mc: ORDER must be 1 or 2");
      end
   endgenerate

   assign tick_s = (cnt_r == '0);
   assign push_s = valid && ready_r;
   assign pop_s  = tick_s && (level_r != '0);

   // Two's complement input becomes offset binary by flipping each channel's MSB.
   always_comb begin
      wr_word_s = data;
      for (int c = 0; c < CHANNELS; c++) begin
         if (SIGNED_IN != 0) wr_word_s[c*W + W - 1] = ~data[c*W + W - 1];
         else                wr_word_s[c*W + W - 1] = data[c*W + W - 1];
      end
   end

   // Occupancy after this cycle's push/pop.
   always_comb begin
      level_next_s = level_r;
      case ({push_s, pop_s})
         2'b10:   level_next_s = level_r + LVL_ONE;
         2'b01:   level_next_s = level_r - LVL_ONE;
         default: level_next_s = level_r;
      endcase
   end

   // Frame storage; contents are don't-care until written, pointers define validity.
   always_ff @(posedge clk) begin
      if (push_s) mem_r[wr_ptr_r] <= wr_word_s;
   end

   // FIFO control, rate counter, fetch pipeline and underrun flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r      <= '0;
         rd_ptr_r      <= '0;
         level_r       <= '0;
         ready_r       <= 1'b1;
         rd_word_r     <= '0;
         cnt_r         <= '0;
         sample_tick_r <= 1'b0;
         load_pend_r   <= 1'b0;
         load_pop_r    <= 1'b0;
         underrun_r    <= 1'b0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_s) begin
            rd_ptr_r  <= rd_ptr_r + PTR_ONE;
            rd_word_r <= mem_r[rd_ptr_r];
         end
         level_r       <= level_next_s;
         ready_r       <= (level_next_s < DEPTH_L);
         cnt_r         <= tick_s ? RELOAD : (cnt_r - CNT_ONE);
         sample_tick_r <= tick_s;
         load_pend_r   <= tick_s;
         load_pop_r    <= pop_s;
         if (tick_s && (level_r == '0)) underrun_r <= 1'b1;
         else if (underrun_clear)       underrun_r <= 1'b0;
      end
   end

   assign ready       = ready_r;
   assign fifo_level  = level_r;
   assign underrun    = underrun_r;
   assign sample_tick = sample_tick_r;

   generate
      for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
         logic [W-1:0] sample_r;
         logic         out_r;

         // Sample register loads two cycles after the tick that fetched it.
         always_ff @(posedge clk) begin
            if (reset) begin
               sample_r <= MID;
            end else if (load_pend_r) begin
               if (load_pop_r)                 sample_r <= rd_word_r[c*W +: W];
               else if (HOLD_ON_UNDERRUN == 0) sample_r <= MID;
            end
         end

         if (ORDER == 1) begin : g_o1
            // The carry out of acc_r is bit W of the W+1-bit accumulator, held in out_r.
            logic [W-1:0] acc_r;
            logic [W:0]   acc_next_s;
            assign acc_next_s = {1'b0, acc_r} + {1'b0, sample_r};

            always_ff @(posedge clk) begin
               if (reset) begin
                  acc_r <= '0;
                  out_r <= 1'b0;
               end else begin
                  acc_r <= acc_next_s[W-1:0];
                  out_r <= acc_next_s[W];
               end
            end
         end else begin : g_o2
            localparam logic signed [W+3:0] FB = {3'b000, 1'b1, {W{1'b0}}};
            logic signed [W+3:0] int1_r, int2_r, int1_next_s, int2_next_s, x_s, fb_s;
            assign x_s         = {4'b0000, sample_r};
            assign fb_s        = out_r ? FB : '0;
            assign int1_next_s = int1_r + x_s - fb_s;
            assign int2_next_s = int2_r + int1_next_s - fb_s;

            always_ff @(posedge clk) begin
               if (reset) begin
                  int1_r <= '0;
                  int2_r <= '0;
                  out_r  <= 1'b0;
               end else begin
                  int1_r <= int1_next_s;
                  int2_r <= int2_next_s;
                  out_r  <= ~int2_next_s[W+3];
               end
            end
         end

         assign audio_out[c] = out_r;
      end
   endgenerate

endmodule

// File: tb/tb_audio_output_mc.sv
// Scoreboard bench for audio_output_mc: two configurations share one stimulus stream and
// are compared cycle by cycle with a queue-based behavioural model, plus density checks.
module tb_audio_output_mc;
   localparam int W     = 16;
   localparam int RF    = 19;
   localparam int DEPTH = 8;
   localparam int FULL  = 65536;
   localparam int MIDV  = 32768;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] data = '0;
   logic        valid = 1'b0;
   logic        underrun_clear = 1'b0;
   logic        ready_a, ready_b, und_a, und_b, tick_a, tick_b;
   logic [3:0]  level_a, level_b;
   logic [1:0]  out_a, out_b;

   int checks = 0;
   int failures = 0;

   typedef struct {int ready; int level; int und; int tick; int oa; int ob;} exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   audio_output_mc #(.CHANNELS(2), .SAMPLE_WIDTH(W), .FIFO_DEPTH_IN_BITS(3), .READ_FREQ(RF),
                     .ORDER(1), .SIGNED_IN(0), .HOLD_ON_UNDERRUN(1)) dut_a (
      .clk(clk), .reset(reset), .data(data), .valid(valid), .ready(ready_a),
      .fifo_level(level_a), .underrun(und_a), .underrun_clear(underrun_clear),
      .sample_tick(tick_a), .audio_out(out_a));

   audio_output_mc #(.CHANNELS(2), .SAMPLE_WIDTH(W), .FIFO_DEPTH_IN_BITS(3), .READ_FREQ(RF),
                     .ORDER(2), .SIGNED_IN(1), .HOLD_ON_UNDERRUN(0)) dut_b (
      .clk(clk), .reset(reset), .data(data), .valid(valid), .ready(ready_b),
      .fifo_level(level_b), .underrun(und_b), .underrun_clear(underrun_clear),
      .sample_tick(tick_b), .audio_out(out_b));

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         if (failures <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   function automatic int wrap20(input int v);
      int t;
      t = v & 1048575;
      if (t >= 524288) t = t - 1048576;
      return t;
   endfunction

   function automatic int conv(input logic [31:0] raw, input int c, input bit sgn);
      logic [15:0] v;
      v = raw[c*16 +: 16];
      if (sgn) v[15] = ~v[15];
      return int'(v);
   endfunction

   // Reference model: FIFO as a queue, tick from a down-counter, each fetched frame lands
   // in the sample registers one edge after the tick edge; modulators from their equations.
   int m_cnt, m_tick, m_und, m_pend, m_pend_pop, lvl0, tk, fb;
   logic [31:0] m_pend_val;
   logic [31:0] fq[$];
   int sa[2], sb[2], acc[2], i1[2], i2[2], oa[2], ob[2];
   exp_t e_m;

   initial begin
      forever begin
         @(posedge clk);
         if (reset) begin
            m_cnt = 0; m_tick = 0; m_und = 0; m_pend = 0; m_pend_pop = 0;
            fq.delete();
            for (int c = 0; c < 2; c++) begin
               sa[c] = MIDV; sb[c] = MIDV; acc[c] = 0; i1[c] = 0; i2[c] = 0; oa[c] = 0; ob[c] = 0;
            end
         end else begin
            tk   = (m_cnt == 0) ? 1 : 0;
            lvl0 = fq.size();
            for (int c = 0; c < 2; c++) begin
               acc[c] = (acc[c] % FULL) + sa[c];
               oa[c]  = (acc[c] >= FULL) ? 1 : 0;
               fb     = (ob[c] != 0) ? FULL : 0;
               i1[c]  = wrap20(i1[c] + sb[c] - fb);
               i2[c]  = wrap20(i2[c] + i1[c] - fb);
               ob[c]  = (i2[c] >= 0) ? 1 : 0;
            end
            if (m_pend != 0) begin
               for (int c = 0; c < 2; c++) begin
                  if (m_pend_pop != 0) begin
                     sa[c] = conv(m_pend_val, c, 1'b0);
                     sb[c] = conv(m_pend_val, c, 1'b1);
                  end else begin
                     sb[c] = MIDV;
                  end
               end
            end
            m_pend     = tk;
            m_pend_pop = (tk != 0 && lvl0 > 0) ? 1 : 0;
            if (m_pend_pop != 0) m_pend_val = fq.pop_front();
            if (valid && lvl0 < DEPTH) fq.push_back(data);
            if (tk != 0 && lvl0 == 0) m_und = 1;
            else if (underrun_clear)  m_und = 0;
            m_cnt  = (tk != 0) ? RF : m_cnt - 1;
            m_tick = tk;
         end
         e_m.ready = (fq.size() < DEPTH) ? 1 : 0;
         e_m.level = fq.size();
         e_m.und   = m_und;
         e_m.tick  = m_tick;
         e_m.oa    = oa[1] * 2 + oa[0];
         e_m.ob    = ob[1] * 2 + ob[0];
         exp_q.push_back(e_m);
      end
   end

   // Monitor: every cycle both DUTs present a full output set to compare.
   exp_t e_c;
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e_c = exp_q.pop_front();
            check("ready_a", int'(ready_a), e_c.ready);
            check("ready_b", int'(ready_b), e_c.ready);
            check("level_a", int'(level_a), e_c.level);
            check("level_b", int'(level_b), e_c.level);
            check("underrun_a", int'(und_a), e_c.und);
            check("underrun_b", int'(und_b), e_c.und);
            check("tick_a", int'(tick_a), e_c.tick);
            check("tick_b", int'(tick_b), e_c.tick);
            check("audio_a", int'(out_a), e_c.oa);
            check("audio_b", int'(out_b), e_c.ob);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int thr, c0, c1, waited;
   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Burst of 10 frames into an empty FIFO: 8 accepted, then full.
      for (int i = 0; i < 10; i++) begin
         valid = 1'b1;
         data  = $urandom;
         @(posedge clk); #1;
      end
      valid = 1'b0;
      check("burst_level", int'(level_a), 8);
      check("burst_ready", int'(ready_a), 0);

      // Random traffic with alternating fill/drain pressure and a reset mid-stream.
      for (int n = 0; n < 3000; n++) begin
         thr = (n / 250) % 4 == 0 ? 1 : ((n / 250) % 4 == 1 ? 0 : ((n / 250) % 4 == 2 ? 9 : 0));
         valid          = ($urandom_range(0, 9) < thr) || (thr == 1 && $urandom_range(0, 3) == 0);
         data           = $urandom;
         underrun_clear = ($urandom_range(0, 49) == 0);
         reset          = (n >= 1500 && n < 1502);
         @(posedge clk); #1;
      end
      valid = 1'b0; underrun_clear = 1'b0; reset = 1'b0;

      // Drain, confirm sticky underrun, then clear it just after a tick.
      repeat (200) @(posedge clk);
      #1;
      check("underrun_sticky", int'(und_a), 1);
      waited = 0;
      while (tick_a !== 1'b1 && waited < 100) begin
         @(posedge clk); #1;
         waited++;
      end
      check("tick_wait_bounded", (waited < 100) ? 1 : 0, 1);
      underrun_clear = 1'b1;
      @(posedge clk); #1;
      underrun_clear = 1'b0;
      check("underrun_cleared_a", int'(und_a), 0);
      check("underrun_cleared_b", int'(und_b), 0);

      // First-order density: 0x8000 alternates, 0x4000 gives one in four.
      reset = 1'b1;
      repeat (2) @(posedge clk); #1;
      reset = 1'b0;
      valid = 1'b1;
      data  = {16'h4000, 16'h8000};
      repeat (80) @(posedge clk);
      #1;
      c0 = 0; c1 = 0;
      for (int k = 0; k < 400; k++) begin
         @(posedge clk); #1;
         c0 += int'(out_a[0]);
         c1 += int'(out_a[1]);
      end
      check("dens_o1_ch0", c0, 200);
      check("dens_o1_ch1", c1, 100);

      // Second-order density on signed input: 0x0000 -> half, 0xC000 -> quarter.
      reset = 1'b1;
      repeat (2) @(posedge clk); #1;
      reset = 1'b0;
      data  = {16'hC000, 16'h0000};
      repeat (80) @(posedge clk);
      #1;
      c0 = 0; c1 = 0;
      for (int k = 0; k < 4096; k++) begin
         @(posedge clk); #1;
         c0 += int'(out_b[0]);
         c1 += int'(out_b[1]);
      end
      check_range("dens_o2_ch0", c0, 2046, 2050);
      check_range("dens_o2_ch1", c1, 1022, 1026);

      valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
